// File: rtl/doodle_pkg.sv
// Shared constants and types for the doodle game datapath: table size,
// sprite geometry, coordinate types and the scanner FSM encoding.
package doodle_pkg;

  localparam int N_PLATFORMS     = 90;
  localparam int PLATFORM_WIDTH  = 100;
  localparam int PLATFORM_HEIGHT = 30;
  localparam int LAND_BAND       = 8;
  localparam int DOODLE_WIDTH    = 80;
  localparam int DOODLE_HEIGHT   = 80;
  localparam int FOOT_INSET      = 16;

  localparam int IDX_W  = 7;
  localparam int PLAT_Y = 0;
  localparam int PLAT_X = 1;

  // Screen coordinate as stored in the platform table (may be negative
  // for entries that have scrolled above the top of the screen).
  typedef logic signed [10:0] coord_t;
  // [PLAT_Y] = top y, [PLAT_X] = left x.
  typedef coord_t [1:0] platform_t;
  // One extra bit so that unsigned doodle coordinates and signed platform
  // coordinates can be compared without wrap.
  typedef logic signed [11:0] wide_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } scan_state_t;

  // Zero-extend an unsigned 11-bit coordinate into the signed compare width.
  function automatic wide_t zext11(input logic [10:0] v);
    return $signed({1'b0, v});
  endfunction

  // Sign-extend a table coordinate into the signed compare width.
  function automatic wide_t sext_coord(input coord_t v);
    return $signed({v[10], v});
  endfunction

endpackage

// File: rtl/platform_collision_scanner_if.sv
// Bundle between the platform generator (master) and the collision
// scanner (slave).
//
// Handshake: calculation_time is a one-cycle start strobe, honoured only
// while busy = 0 (a strobe while busy = 1 is dropped and sets the sticky
// overrun flag). done is a one-cycle completion pulse; move_collision and
// hit_index are valid from the done cycle and hold until the next strobe
// edge clears move_collision. The platform table must be stable outside
// strobe cycles, because the scanner reads it live while busy.
interface platform_collision_scanner_if;
  import doodle_pkg::*;

  logic                           calculation_time;
  logic [10:0]                    doodle_x;
  logic [9:0]                     doodle_y;
  logic                           doodle_falling;
  platform_t [N_PLATFORMS-1:0]    platforms;
  logic [N_PLATFORMS-1:0]         platform_activation;
  logic                           move_collision;
  logic [IDX_W-1:0]               hit_index;
  logic                           busy;
  logic                           done;
  logic                           overrun;
  scan_state_t                    dbg_state;

  modport master (
    output calculation_time, doodle_x, doodle_y, doodle_falling,
           platforms, platform_activation,
    input  move_collision, hit_index, busy, done, overrun, dbg_state
  );

  modport slave (
    input  calculation_time, doodle_x, doodle_y, doodle_falling,
           platforms, platform_activation,
    output move_collision, hit_index, busy, done, overrun, dbg_state
  );

endinterface

// File: rtl/platform_hit_check.sv
// Single-entry landing test: is an active platform's top band under the
// doodle's feet, with horizontal overlap of the trimmed foot hitbox?
// Purely combinational; the scanner time-multiplexes it over the table.
module platform_hit_check
  import doodle_pkg::*;
(
  input  platform_t i_plat,
  input  logic      i_active,
  input  wide_t     i_feet_y,
  input  wide_t     i_foot_left,
  input  wide_t     i_foot_right,
  output logic      o_hit
);

  wide_t w_py;
  wide_t w_px;
  wide_t w_band_bot;
  wide_t w_plat_right;
  logic  w_vert_ok;
  logic  w_horz_ok;

  assign w_py         = sext_coord(i_plat[PLAT_Y]);
  assign w_px         = sext_coord(i_plat[PLAT_X]);
  assign w_band_bot   = w_py + wide_t'(LAND_BAND - 1);
  assign w_plat_right = w_px + wide_t'(PLATFORM_WIDTH - 1);

  // Feet must land within the top LAND_BAND rows; feet and both foot edges
  // are compared signed so entries above the screen never wrap into range.
  always_comb begin
    w_vert_ok = (i_feet_y >= w_py) && (i_feet_y <= w_band_bot);
    w_horz_ok = (i_foot_left <= w_plat_right) && (i_foot_right >= w_px);
    o_hit     = i_active && w_vert_ok && w_horz_ok;
  end

endmodule

// File: rtl/platform_collision_scanner.sv
// Frame-rate collision scanner: on each calculation_time strobe it walks
// the platform table one entry per cycle, captures the lowest-index landing
// and reports it after a fixed N_PLATFORMS + 2 cycle latency.
module platform_collision_scanner
  import doodle_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  platform_collision_scanner_if.slave   bus
);

  scan_state_t      r_state;
  scan_state_t      w_next_state;

  logic             w_start;
  logic             w_scan;
  logic             w_report;
  logic             w_busy;
  logic             w_last;

  logic [IDX_W-1:0] r_idx;
  logic [10:0]      r_snap_x;
  logic [9:0]       r_snap_y;
  logic             r_snap_fall;
  logic             r_hit_flag;
  logic [IDX_W-1:0] r_hit_idx;

  logic             r_move_collision;
  logic [IDX_W-1:0] r_hit_index;
  logic             r_done;
  logic             r_overrun;

  wide_t            w_feet_y;
  wide_t            w_foot_left;
  wide_t            w_foot_right;
  logic             w_entry_hit;

  assign w_last = (r_idx == IDX_W'(N_PLATFORMS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: strobe starts a scan, full table walk, one report cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (bus.calculation_time) w_next_state = ST_SCAN;
      ST_SCAN:   if (w_last)               w_next_state = ST_REPORT;
      ST_REPORT:                           w_next_state = ST_IDLE;
      default:                             w_next_state = ST_IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    w_start  = 1'b0;
    w_scan   = 1'b0;
    w_report = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      ST_IDLE:   w_start = bus.calculation_time;
      ST_SCAN:   begin w_scan = 1'b1;   w_busy = 1'b1; end
      ST_REPORT: begin w_report = 1'b1; w_busy = 1'b1; end
      default:   ;
    endcase
  end

  // Foot hitbox derived from the frame snapshot, not the live doodle inputs.
  always_comb begin
    w_feet_y     = $signed({2'b00, r_snap_y}) + wide_t'(DOODLE_HEIGHT - 1);
    w_foot_left  = zext11(r_snap_x) + wide_t'(FOOT_INSET);
    w_foot_right = zext11(r_snap_x) + wide_t'(DOODLE_WIDTH - 1 - FOOT_INSET);
  end

  platform_hit_check u_hit_check (
    .i_plat       (bus.platforms[r_idx]),
    .i_active     (bus.platform_activation[r_idx] & r_snap_fall),
    .i_feet_y     (w_feet_y),
    .i_foot_left  (w_foot_left),
    .i_foot_right (w_foot_right),
    .o_hit        (w_entry_hit)
  );

  // Snapshot, index walk and first-hit capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_snap_x    <= '0;
      r_snap_y    <= '0;
      r_snap_fall <= 1'b0;
      r_hit_flag  <= 1'b0;
      r_hit_idx   <= '0;
    end else if (w_start) begin
      r_idx       <= '0;
      r_snap_x    <= bus.doodle_x;
      r_snap_y    <= bus.doodle_y;
      r_snap_fall <= bus.doodle_falling;
      r_hit_flag  <= 1'b0;
      r_hit_idx   <= '0;
    end else if (w_scan) begin
      if (w_entry_hit && !r_hit_flag) begin
        r_hit_flag <= 1'b1;
        r_hit_idx  <= r_idx;
      end
      if (!w_last) r_idx <= r_idx + 1'b1;
    end else if (w_report) begin
      r_idx <= '0;
    end
  end

  // Result registers: move_collision holds through the start cycle (the
  // generator samples it there) and is cleared at the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_move_collision <= 1'b0;
      r_hit_index      <= '0;
      r_done           <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      r_done <= w_report;
      if (w_start) r_move_collision <= 1'b0;
      if (w_report) begin
        r_move_collision <= r_hit_flag;
        r_hit_index      <= r_hit_flag ? r_hit_idx : '0;
      end
      if (w_busy && bus.calculation_time) r_overrun <= 1'b1;
    end
  end

  assign bus.move_collision = r_move_collision;
  assign bus.hit_index      = r_hit_index;
  assign bus.busy           = w_busy;
  assign bus.done           = r_done;
  assign bus.overrun        = r_overrun;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_platform_collision_scanner.sv
// Directed bench for the collision scanner: landing hit, not-falling,
// first-hit priority, hitbox edges, overrun and mid-scan reset.
module tb_platform_collision_scanner;
  import doodle_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;
  int   cnt;

  platform_collision_scanner_if bus ();

  platform_collision_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_table();
    bus.platforms           = '0;
    bus.platform_activation = '0;
  endtask

  task automatic set_plat(input int i, input int y, input int x, input logic act);
    bus.platforms[i][PLAT_Y]  = coord_t'(y);
    bus.platforms[i][PLAT_X]  = coord_t'(x);
    bus.platform_activation[i] = act;
  endtask

  task automatic set_doodle(input int x, input int y, input logic fall);
    bus.doodle_x       = 11'(x);
    bus.doodle_y       = 10'(y);
    bus.doodle_falling = fall;
  endtask

  // One-cycle strobe; on return the bench sits in cycle start+1.
  task automatic start_scan();
    bus.calculation_time = 1'b1;
    step();
    bus.calculation_time = 1'b0;
  endtask

  // Wait for done, counting cycles from start (lat = 1 in cycle start+1).
  // A second strobe is injected in cycle start+inject_at (0 = none).
  task automatic wait_done(input int inject_at, output int l);
    l = 1;
    while (bus.done !== 1'b1 && l < 200) begin
      if (l == inject_at) bus.calculation_time = 1'b1;
      step();
      bus.calculation_time = 1'b0;
      l++;
    end
  endtask

  task automatic full_scan(input string tag, input logic exp_mc, input int exp_idx);
    start_scan();
    wait_done(0, lat);
    chk({tag, "_latency"}, lat, 92);
    chk({tag, "_mc"}, bus.move_collision, exp_mc);
    chk({tag, "_idx"}, bus.hit_index, exp_idx);
    step();
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.calculation_time = 1'b0;
    set_doodle(350, 0, 1'b1);
    clear_table();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state.
    chk("rst_mc",      bus.move_collision, 0);
    chk("rst_idx",     bus.hit_index, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_done",    bus.done, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_state",   32'(bus.dbg_state), 32'(ST_IDLE));

    // Feet = 79 on platform 5 top (79), foot span 366..413 over 342..441.
    set_plat(5, 79, 342, 1'b1);
    start_scan();
    chk("a_busy", bus.busy, 1);
    chk("a_state", 32'(bus.dbg_state), 32'(ST_SCAN));
    wait_done(0, lat);
    chk("a_latency", lat, 92);
    chk("a_mc", bus.move_collision, 1);
    chk("a_idx", bus.hit_index, 5);
    chk("a_busy_done", bus.busy, 0);
    step();
    chk("a_done_pulse", bus.done, 0);
    chk("a_mc_hold", bus.move_collision, 1);

    // Not falling: no landing; previous result visible in the start cycle.
    set_doodle(350, 0, 1'b0);
    bus.calculation_time = 1'b1;
    chk("b_mc_start_cycle", bus.move_collision, 1);
    step();
    bus.calculation_time = 1'b0;
    chk("b_mc_cleared", bus.move_collision, 0);
    wait_done(0, lat);
    chk("b_latency", lat, 92);
    chk("b_mc", bus.move_collision, 0);
    chk("b_idx", bus.hit_index, 0);
    step();

    // First hit wins.
    set_doodle(350, 0, 1'b1);
    clear_table();
    set_plat(4, 79, 342, 1'b1);
    set_plat(7, 79, 342, 1'b1);
    full_scan("c_both", 1'b1, 4);
    bus.platform_activation[4] = 1'b0;
    full_scan("c_second", 1'b1, 7);

    // Horizontal edge: foot left 441 vs platform right 441, then 442.
    clear_table();
    set_plat(5, 79, 342, 1'b1);
    set_doodle(425, 0, 1'b1);
    full_scan("h_edge_in", 1'b1, 5);
    set_doodle(426, 0, 1'b1);
    full_scan("h_edge_out", 1'b0, 0);

    // Vertical edge with feet = 79: py = 72 in band, py = 71 out, py = -30 out.
    set_doodle(350, 0, 1'b1);
    clear_table();
    set_plat(10, 72, 342, 1'b1);
    full_scan("v_edge_in", 1'b1, 10);
    set_plat(10, 71, 342, 1'b1);
    full_scan("v_edge_out", 1'b0, 0);
    set_plat(10, -30, 342, 1'b1);
    full_scan("v_negative", 1'b0, 0);

    // Strobe while busy: ignored for the scan, sets sticky overrun.
    set_plat(10, 72, 342, 1'b1);
    set_doodle(350, 0, 1'b1);
    start_scan();
    set_doodle(600, 0, 1'b1);
    wait_done(40, lat);
    chk("o_latency", lat, 92);
    chk("o_mc", bus.move_collision, 1);
    chk("o_idx", bus.hit_index, 10);
    chk("o_overrun", bus.overrun, 1);
    step();
    chk("o_idle_after", bus.busy, 0);
    set_doodle(350, 0, 1'b1);
    full_scan("o_next", 1'b1, 10);
    chk("o_overrun_sticky", bus.overrun, 1);

    // Reset mid-scan at start+50.
    start_scan();
    lat = 1;
    while (lat < 50) begin
      step();
      lat++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_mc", bus.move_collision, 0);
    chk("r_idx", bus.hit_index, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_done", bus.done, 0);
    chk("r_overrun", bus.overrun, 0);
    chk("r_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done === 1'b1) cnt++;
      step();
    end
    chk("r_no_done", cnt, 0);
    full_scan("r_clean", 1'b1, 10);
    chk("r_clean_overrun", bus.overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
